// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, stall/flush/forward controls and counters out.
// master = pipeline side (drives status), slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_dest;
    logic             ex_write_enable;
    logic             ex_is_load;
    logic [4:0]       mem_dest;
    logic             mem_write_enable;
    logic             branch_taken;
    logic             ext_stall;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       fwd_sel_rs1;
    logic [1:0]       fwd_sel_rs2;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_dest, ex_write_enable, ex_is_load,
               mem_dest, mem_write_enable, branch_taken, ext_stall,
        input  pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
               fwd_sel_rs1, fwd_sel_rs2, ctrl_state, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_dest, ex_write_enable, ex_is_load,
               mem_dest, mem_write_enable, branch_taken, ext_stall,
        output pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
               fwd_sel_rs1, fwd_sel_rs2, ctrl_state, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: same-cycle stall/flush, registered forwarding selects,
// branch-flush / memory-wait sequencing and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             pend_q, pend_d;
    logic [1:0]       fwd1_q, fwd1_d;
    logic [1:0]       fwd2_q, fwd2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_evt_cnt_q, flush_evt_cnt_d;

    logic luh;
    logic br_issue;
    logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush;

    function automatic logic [1:0] fwd_pick(
        input logic [4:0] rs,
        input logic       ex_we,
        input logic [4:0] ex_rd,
        input logic       ex_ld,
        input logic       mem_we,
        input logic [4:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && ex_we && ex_rd == rs && !ex_ld) begin
            sel = 2'b01;
        end else if (rs != 5'd0 && mem_we && mem_rd == rs) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign luh = bus.id_valid & bus.ex_is_load & bus.ex_write_enable & (bus.ex_dest != 5'd0) &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_dest)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_dest)));

    // A branch deferred by a memory wait is issued on the first cycle the wait clears.
    assign br_issue = !bus.ext_stall && (state_q != ST_FLUSH) &&
                      (bus.branch_taken || (state_q == ST_WAIT && pend_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            flush_cnt_q     <= 3'd0;
            pend_q          <= 1'b0;
            fwd1_q          <= 2'b00;
            fwd2_q          <= 2'b00;
            stall_cnt_q     <= '0;
            flush_evt_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            pend_q          <= pend_d;
            fwd1_q          <= fwd1_d;
            fwd2_q          <= fwd2_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_evt_cnt_q <= flush_evt_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        case (state_q)
            ST_RUN: begin
                if (bus.ext_stall) begin
                    state_d = ST_WAIT;
                    pend_d  = bus.branch_taken;
                end else if (br_issue && FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (!bus.ext_stall) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.ext_stall) begin
                    pend_d = pend_q | bus.branch_taken;
                end else begin
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                    if (br_issue && FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (state_q == ST_FLUSH) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_stall    = bus.ext_stall;
            if_id_stall = bus.ext_stall;
            id_ex_stall = bus.ext_stall;
        end else if (bus.ext_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (br_issue) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (luh) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
        if (!id_ex_stall) begin
            if (id_ex_flush) begin
                fwd1_d = 2'b00;
                fwd2_d = 2'b00;
            end else begin
                fwd1_d = fwd_pick(bus.id_rs1, bus.ex_write_enable, bus.ex_dest, bus.ex_is_load,
                                  bus.mem_write_enable, bus.mem_dest);
                fwd2_d = fwd_pick(bus.id_rs2, bus.ex_write_enable, bus.ex_dest, bus.ex_is_load,
                                  bus.mem_write_enable, bus.mem_dest);
            end
        end
    end

    always_comb begin
        stall_cnt_d     = stall_cnt_q;
        flush_evt_cnt_d = flush_evt_cnt_q;
        if (pc_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_issue && flush_evt_cnt_q != {CNT_W{1'b1}}) begin
            flush_evt_cnt_d = flush_evt_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_stall    = pc_stall;
    assign bus.if_id_stall = if_id_stall;
    assign bus.id_ex_stall = id_ex_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.fwd_sel_rs1 = fwd1_q;
    assign bus.fwd_sel_rs2 = fwd2_q;
    assign bus.ctrl_state  = state_q;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_evt_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model queues expected outputs as each
// cycle's stimulus is driven; they are popped and compared at the following negedge.
module tb_pipe_hazard_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             skip;
        logic             pc_stall;
        logic             if_id_stall;
        logic             id_ex_stall;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             flush_evt;
        logic [1:0]       fwd1;
        logic [1:0]       fwd2;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [1:0] m_st;
    int         m_left;
    logic       m_pend;
    logic [1:0] m_f1, m_f2;
    int         m_sc, m_fc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (bus.ex_write_enable && !bus.ex_is_load && bus.ex_dest == rs) return 2'b01;
        if (bus.mem_write_enable && bus.mem_dest == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.ex_dest = 0; bus.ex_write_enable = 0; bus.ex_is_load = 0;
        bus.mem_dest = 0; bus.mem_write_enable = 0;
        bus.branch_taken = 0; bus.ext_stall = 0;
    endtask

    task automatic model_expect(output exp_t e);
        logic hz;
        e = '0;
        hz = bus.id_valid && bus.ex_is_load && bus.ex_write_enable && bus.ex_dest != 0 &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_dest) ||
              (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_dest));
        if (m_st == 2'b01) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
            e.pc_stall = bus.ext_stall; e.if_id_stall = bus.ext_stall; e.id_ex_stall = bus.ext_stall;
        end else if (bus.ext_stall) begin
            e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_stall = 1;
        end else if (bus.branch_taken || (m_st == 2'b10 && m_pend)) begin
            e.if_id_flush = 1; e.id_ex_flush = 1; e.flush_evt = 1;
        end else if (hz) begin
            e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_flush = 1;
        end
        e.skip = rst;
        e.fwd1 = m_f1; e.fwd2 = m_f2; e.st = m_st;
        e.sc = m_sc[CNT_W-1:0]; e.fc = m_fc[CNT_W-1:0];
    endtask

    task automatic model_advance(input exp_t e);
        if (rst) begin
            m_st = 0; m_left = 0; m_pend = 0; m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0;
            return;
        end
        if (e.pc_stall && m_sc < CNT_MAX) m_sc++;
        if (e.flush_evt && m_fc < CNT_MAX) m_fc++;
        if (!e.id_ex_stall) begin
            m_f1 = e.id_ex_flush ? 2'b00 : exp_fwd(bus.id_rs1);
            m_f2 = e.id_ex_flush ? 2'b00 : exp_fwd(bus.id_rs2);
        end
        if (m_st == 2'b01) begin
            if (!bus.ext_stall) begin
                m_left--;
                if (m_left == 0) m_st = 2'b00;
            end
        end else if (bus.ext_stall) begin
            m_pend = (m_st == 2'b10) ? (m_pend | bus.branch_taken) : bus.branch_taken;
            m_st   = 2'b10;
        end else begin
            m_pend = 0;
            m_st   = 2'b00;
            if (e.flush_evt && FLUSH_CYCLES > 1) begin
                m_st   = 2'b01;
                m_left = FLUSH_CYCLES - 1;
            end
        end
    endtask

    task automatic step();
        exp_t e, got;
        model_expect(e);
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        if (!got.skip) begin
            check_val("pc_stall",    32'(bus.pc_stall),    32'(got.pc_stall));
            check_val("if_id_stall", 32'(bus.if_id_stall), 32'(got.if_id_stall));
            check_val("id_ex_stall", 32'(bus.id_ex_stall), 32'(got.id_ex_stall));
            check_val("if_id_flush", 32'(bus.if_id_flush), 32'(got.if_id_flush));
            check_val("id_ex_flush", 32'(bus.id_ex_flush), 32'(got.id_ex_flush));
            check_val("fwd_sel_rs1", 32'(bus.fwd_sel_rs1), 32'(got.fwd1));
            check_val("fwd_sel_rs2", 32'(bus.fwd_sel_rs2), 32'(got.fwd2));
            check_val("ctrl_state",  32'(bus.ctrl_state),  32'(got.st));
            check_val("stall_count", 32'(bus.stall_count), 32'(got.sc));
            check_val("flush_count", 32'(bus.flush_count), 32'(got.fc));
        end
        @(posedge clk);
        model_advance(e);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_st = 0; m_left = 0; m_pend = 0; m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0;
        set_idle();
        rst = 1;
        step();
        step();
        rst = 0;
        repeat (5) step();
        check_val("reset_state", 32'(bus.ctrl_state), 32'd0);

        // load-use on rs2, then EX holds the bubble
        bus.id_valid = 1; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
        bus.ex_is_load = 1; bus.ex_write_enable = 1; bus.ex_dest = 5;
        step();
        bus.ex_is_load = 0; bus.ex_write_enable = 0; bus.ex_dest = 0;
        step();
        check_val("luh_stall_count", 32'(bus.stall_count), 32'd1);
        check_val("luh_fwd_rs2", 32'(bus.fwd_sel_rs2), 32'd0);

        do_reset();
        bus.branch_taken = 1;
        step();
        step();
        bus.branch_taken = 0;
        repeat (3) step();
        check_val("br_flush_count", 32'(bus.flush_count), 32'd1);

        do_reset();
        bus.ext_stall = 1;
        step();
        bus.branch_taken = 1;
        step();
        bus.branch_taken = 0;
        step();
        bus.ext_stall = 0;
        repeat (4) step();
        check_val("wait_flush_count", 32'(bus.flush_count), 32'd1);
        check_val("wait_stall_count", 32'(bus.stall_count), 32'd3);

        do_reset();
        bus.ex_write_enable = 1; bus.ex_dest = 7; bus.mem_write_enable = 1; bus.mem_dest = 7;
        bus.id_rs1 = 7;
        step();
        check_val("fwd_ex_wins", 32'(bus.fwd_sel_rs1), 32'd1);
        bus.ex_write_enable = 0;
        step();
        check_val("fwd_mem", 32'(bus.fwd_sel_rs1), 32'd2);
        bus.id_rs1 = 0; bus.ex_dest = 0; bus.ex_write_enable = 1; bus.mem_dest = 0;
        step();
        check_val("fwd_x0", 32'(bus.fwd_sel_rs1), 32'd0);
        bus.id_rs2 = 9; bus.ex_dest = 9; bus.ex_is_load = 1; bus.mem_dest = 9;
        step();
        check_val("fwd_load_mem", 32'(bus.fwd_sel_rs2), 32'd2);
        bus.ex_is_load = 0; bus.ext_stall = 1;
        step();
        check_val("fwd_hold", 32'(bus.fwd_sel_rs2), 32'd2);
        set_idle();
        step();

        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.id_valid         = 1'($urandom_range(0, 3) != 0);
            bus.id_rs1           = 5'($urandom_range(0, 3));
            bus.id_rs2           = 5'($urandom_range(0, 3));
            bus.id_uses_rs1      = 1'($urandom_range(0, 1));
            bus.id_uses_rs2      = 1'($urandom_range(0, 1));
            bus.ex_dest          = 5'($urandom_range(0, 3));
            bus.ex_write_enable  = 1'($urandom_range(0, 1));
            bus.ex_is_load       = 1'($urandom_range(0, 2) == 0);
            bus.mem_dest         = 5'($urandom_range(0, 3));
            bus.mem_write_enable = 1'($urandom_range(0, 1));
            bus.branch_taken     = 1'($urandom_range(0, 7) == 0);
            bus.ext_stall        = 1'($urandom_range(0, 5) == 0);
            step();
        end

        do_reset();
        bus.branch_taken = 1;
        step();
        bus.branch_taken = 0;
        rst = 1;
        step();
        rst = 0;
        step();
        check_val("rst_flush_off", 32'(bus.if_id_flush), 32'd0);
        check_val("rst_state", 32'(bus.ctrl_state), 32'd0);
        check_val("rst_flush_count", 32'(bus.flush_count), 32'd0);

        bus.ext_stall = 1;
        repeat (CNT_MAX + 4) step();
        check_val("stall_sat", 32'(bus.stall_count), 32'(CNT_MAX));
        bus.ext_stall = 0;
        step();
        bus.id_valid = 1; bus.id_rs1 = 3; bus.id_uses_rs1 = 1;
        bus.ex_is_load = 1; bus.ex_write_enable = 1; bus.ex_dest = 3;
        step();
        set_idle();
        step();
        check_val("stall_sat_hold", 32'(bus.stall_count), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage integer pipeline (IF/ID/EX/MEM/WB).
- Generates the per-cycle stall and flush controls for the PC and pipeline registers.
- Schedules registered forwarding selects for the EX-stage operand muxes.
- Sequences branch flushes and external memory waits, and keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles flush is asserted after a taken branch (legal range 1..7).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- id_valid  input  1  ID stage holds a valid instruction
- id_rs1  input  5  ID source register 1
- id_rs2  input  5  ID source register 2
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_dest  input  5  EX destination register
- ex_write_enable  input  1  EX instruction writes the register file
- ex_is_load  input  1  EX instruction is a load
- mem_dest  input  5  MEM destination register
- mem_write_enable  input  1  MEM instruction writes the register file
- branch_taken  input  1  EX resolved a taken branch or jump this cycle
- ext_stall  input  1  data memory not ready; freeze the whole pipe
- pc_stall  output  1  hold PC
- if_id_stall  output  1  hold IF/ID register
- id_ex_stall  output  1  hold ID/EX register
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_flush  output  1  load bubble into ID/EX
- fwd_sel_rs1  output  2  EX operand1 source: 00 regfile, 01 MEM result, 10 WB result
- fwd_sel_rs2  output  2  EX operand2 source, same encoding
- ctrl_state  output  2  00 RUN, 01 FLUSH, 10 MEM_WAIT
- stall_count  output  CNT_W  cycles with pc_stall=1, saturating
- flush_count  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - ctrl_state=RUN; fwd_sel_*=00; counters=0; flush_cnt=0; pending_flush=0.
  - All stall/flush outputs read 0 in the cycle after reset.
  - Reset mid-FLUSH or mid-MEM_WAIT aborts the sequence with no residual flush.
- Stall and flush outputs are combinational from current state and inputs (same-cycle). fwd_sel_*, ctrl_state and counters are registered.
- Load-use hazard luh:
  - luh = id_valid & ex_is_load & ex_write_enable & ex_dest!=0 & ((id_uses_rs1 & id_rs1==ex_dest) | (id_uses_rs2 & id_rs2==ex_dest)).
- Priority within a cycle: ext_stall > branch_taken > luh.
- RUN state:
  - ext_stall=1: pc_stall=if_id_stall=id_ex_stall=1, no flush. Next state MEM_WAIT; pending_flush<=branch_taken.
  - else branch_taken=1: if_id_flush=id_ex_flush=1; flush_count++. If FLUSH_CYCLES>1, next state FLUSH with flush_cnt<=FLUSH_CYCLES-1; otherwise remain in RUN.
  - else luh=1: pc_stall=if_id_stall=1, id_ex_flush=1 (exactly one bubble). Next state RUN.
  - luh is not re-detected next cycle because EX then holds the bubble.
- FLUSH state:
  - if_id_flush=id_ex_flush=1; flush_cnt decrements; RUN when flush_cnt reaches 1→0.
  - branch_taken is ignored (the branch is squashed).
  - ext_stall=1 freezes flush_cnt: stall outputs are asserted and flush outputs are still asserted.
- MEM_WAIT state:
  - All three stalls asserted while ext_stall=1; branch_taken ORs into pending_flush.
  - When ext_stall=0: return to RUN. If pending_flush=1, that cycle behaves as a RUN-state branch_taken (flush issued, flush_count++, FLUSH entered per FLUSH_CYCLES); pending_flush<=0.
- Forwarding select, updated only when id_ex_stall=0:
  - If id_ex_flush=1: fwd_sel_*<=00.
  - Else for each rsN: 01 if ex_write_enable & ex_dest==rsN & rsN!=0 & !ex_is_load; else 10 if mem_write_enable & mem_dest==rsN & rsN!=0; else 00.
  - MEM source wins over WB source. Register x0 is never forwarded.
  - When id_ex_stall=1, fwd_sel_* hold their value.
- Counters:
  - stall_count increments every cycle pc_stall=1.
  - Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset then idle (all inputs 0) for 5 cycles -> all outputs 0, ctrl_state=00, counters 0.
- EX: ex_is_load=1, ex_write_enable=1, ex_dest=5; ID: id_rs2=5, id_uses_rs2=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, fwd_sel_rs2=00 next cycle, stall_count=1.
- branch_taken pulse one cycle, FLUSH_CYCLES=2 -> if_id_flush/id_ex_flush high exactly 2 cycles, ctrl_state 00→01→00, flush_count=1; second branch_taken during FLUSH ignored.
- ext_stall high 3 cycles with branch_taken pulse in cycle 2 -> stalls high 3 cycles, no flush during them; flush starts the cycle ext_stall drops; flush_count=1, stall_count=3.
- Forwarding: EX writes x7 (non-load), MEM writes x7, id_rs1=7 -> fwd_sel_rs1=01. EX not writing, MEM writes x7 -> 10. id_rs1=0 with ex_dest=0 -> 00.
- rst asserted in the first FLUSH cycle -> next cycle flushes 0, ctrl_state=00, flush_count=0; drive stall_count to 0xFFFF and stall again -> stays 0xFFFF.
